// File: rtl/npu_out_collector.sv
// npu_out_collector: captures per-lane results from the arithmetic stage into a
// small FIFO, then serializes each entry lane by lane, lowest enabled lane first.
// Each transferred byte is tagged with a (column, row) write-back address that
// advances on every handshake and wraps over the feature-map dimensions.
module npu_out_collector #(
  parameter int WIDTH    = 80,
  parameter int HEIGHT   = 8,
  parameter int WIDTH_B  = 7,
  parameter int HEIGHT_B = 3,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         out,
  input  logic [7:0]          out_en,
  input  logic                frame_start,
  output logic [7:0]          m_data,
  output logic [WIDTH_B-1:0]  m_w,
  output logic [HEIGHT_B-1:0] m_h,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                full,
  output logic                overflow,
  output logic                busy
);

  // DEPTH is a power of two (>= 2), so pointers wrap naturally at PTR_W bits.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(DEPTH);
  localparam logic [WIDTH_B-1:0]  W_LAST  = WIDTH_B'(WIDTH - 1);
  localparam logic [HEIGHT_B-1:0] H_LAST  = HEIGHT_B'(HEIGHT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;

  logic [71:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [63:0]         hold_data_q;
  logic [7:0]          hold_mask_q;

  logic [WIDTH_B-1:0]  w_q;
  logic [HEIGHT_B-1:0] h_q;
  logic                ovf_q;

  logic                push, pop, push_ok, drop;
  logic                fifo_empty, fifo_full;
  logic [2:0]          sel;
  logic [7:0]          mask_rest;
  logic                fire, last;

  assign push       = |out_en;
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);
  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  // Pick the lowest-indexed lane still pending in the hold register.
  always_comb begin
    sel = '0;
    for (int i = 7; i >= 0; i--) begin
      if (hold_mask_q[i]) sel = 3'(i);
    end
  end

  assign mask_rest = hold_mask_q & ~(8'b1 << sel);
  assign fire      = (state_q == SEND) && m_ready;
  assign last      = (mask_rest == '0);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and FIFO pop decision; a last-byte handshake reloads hold without a bubble.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fire && last) begin
          if (!fifo_empty) pop     = 1'b1;
          else             state_d = IDLE;
        end
      end
    endcase
  end

  // FSM outputs and status flags; m_data is forced to zero outside SEND.
  always_comb begin
    m_valid  = (state_q == SEND);
    m_data   = (state_q == SEND) ? hold_data_q[8*sel +: 8] : 8'h00;
    m_w      = w_q;
    m_h      = h_q;
    overflow = ovf_q;
    full     = fifo_full;
    busy     = !fifo_empty || (state_q == SEND);
  end

  // FIFO occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
  end

  // FIFO pointers and occupancy; reset empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage write, {data, mask} per entry.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {out, out_en};
  end

  // Hold register: load on pop, otherwise retire the lane just transferred.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data_q <= '0;
      hold_mask_q <= '0;
    end else if (pop) begin
      {hold_data_q, hold_mask_q} <= mem_q[rd_ptr_q];
    end else if (fire) begin
      hold_mask_q <= mask_rest;
    end
  end

  // Write-back address counters; frame_start overrides a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q <= '0;
      h_q <= '0;
    end else if (frame_start) begin
      w_q <= '0;
      h_q <= '0;
    end else if (fire) begin
      if (w_q == W_LAST) begin
        w_q <= '0;
        h_q <= (h_q == H_LAST) ? '0 : h_q + 1'b1;
      end else begin
        w_q <= w_q + 1'b1;
      end
    end
  end

  // Sticky overflow flag; a drop in the same cycle as frame_start keeps it set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           ovf_q <= 1'b0;
    else if (drop)        ovf_q <= 1'b1;
    else if (frame_start) ovf_q <= 1'b0;
  end

endmodule

// File: tb/tb_npu_out_collector.sv
// Bench for npu_out_collector: directed steps plus a random phase, checked
// against a transaction-level model (expected byte queue + linear byte index).
module tb_npu_out_collector;

  localparam int WIDTH    = 80;
  localparam int HEIGHT   = 8;
  localparam int WIDTH_B  = 7;
  localparam int HEIGHT_B = 3;
  localparam int DEPTH    = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [63:0]         out;
  logic [7:0]          out_en;
  logic                frame_start;
  logic [7:0]          m_data;
  logic [WIDTH_B-1:0]  m_w;
  logic [HEIGHT_B-1:0] m_h;
  logic                m_valid;
  logic                m_ready;
  logic                full;
  logic                overflow;
  logic                busy;

  int checks = 0;
  int errors = 0;

  // Model: bytes still owed in order, bytes left per outstanding entry,
  // and number of bytes transferred since the last frame_start/reset.
  logic [7:0] exp_q[$];
  int         rem_q[$];
  int         idx = 0;

  logic                last_valid;
  logic [7:0]          last_data;
  logic [WIDTH_B-1:0]  last_w;
  logic [HEIGHT_B-1:0] last_h;

  always #5 clk = ~clk;

  npu_out_collector #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .WIDTH_B(WIDTH_B), .HEIGHT_B(HEIGHT_B), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .out(out), .out_en(out_en), .frame_start(frame_start),
    .m_data(m_data), .m_w(m_w), .m_h(m_h), .m_valid(m_valid), .m_ready(m_ready),
    .full(full), .overflow(overflow), .busy(busy)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enqueue(input logic [7:0] en, input logic [63:0] d);
    for (int i = 0; i < 8; i++)
      if (en[i]) exp_q.push_back(d[8*i +: 8]);
    rem_q.push_back($countones(en));
  endtask

  // One clock cycle: drive inputs, sample at negedge, score any handshake,
  // record captures (unless the step is expected to be dropped).
  task automatic step(input logic [7:0] en, input logic [63:0] d, input logic rdy,
                      input logic fs, input logic keep);
    logic hs;
    out_en = en; out = d; m_ready = rdy; frame_start = fs;
    @(negedge clk);
    last_valid = m_valid; last_data = m_data; last_w = m_w; last_h = m_h;
    hs = m_valid && rdy;
    if (hs) begin
      chk("sb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk("sb_data", 32'(m_data), 32'(exp_q[0]));
        chk("sb_w", 32'(m_w), 32'(idx % WIDTH));
        chk("sb_h", 32'(m_h), 32'((idx / WIDTH) % HEIGHT));
        void'(exp_q.pop_front());
        if (rem_q.size() != 0) begin
          rem_q[0] = rem_q[0] - 1;
          if (rem_q[0] == 0) void'(rem_q.pop_front());
        end
      end
    end
    if (en != 8'h00 && keep) enqueue(en, d);
    @(posedge clk); #1;
    if (hs) idx++;
    if (fs) idx = 0;
    out_en = 8'h00; frame_start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  en, sd;
    logic [WIDTH_B-1:0]  sw;
    logic [HEIGHT_B-1:0] sh;
    int run, maxrun, lane;

    reset = 1'b1; out = '0; out_en = '0; frame_start = 1'b0; m_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_w", 32'(m_w), 32'd0);
    chk("rst_h", 32'(m_h), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single entry right after reset, two-cycle latency, sparse mask.
    d = 64'h1716_1514_1312_1110;
    step(8'hA5, d, 1'b1, 1'b0, 1'b1);
    chk("lat_cap", 32'(last_valid), 32'd0);
    step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    chk("lat_t", 32'(last_valid), 32'd0);
    step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    chk("lat_t1", 32'(last_valid), 32'd1);
    chk("b0_data", 32'(last_data), 32'h10);
    step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    chk("b1_data", 32'(last_data), 32'h12);
    step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    chk("b2_data", 32'(last_data), 32'h15);
    step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    chk("b3_data", 32'(last_data), 32'h17);
    chk("b3_w", 32'(last_w), 32'd3);
    chk("b3_valid", 32'(last_valid), 32'd1);
    step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    chk("single_done", 32'(last_valid), 32'd0);

    // Backpressure for 5 cycles mid-entry.
    d = {$urandom, $urandom};
    step(8'hFF, d, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6 && !last_valid; k++) step(8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
    chk("bp_valid", 32'(last_valid), 32'd1);
    sd = last_data; sw = last_w; sh = last_h;
    for (int k = 0; k < 5; k++) begin
      step(8'h00, 64'h0, 1'b0, 1'b0, 1'b1);
      chk("bp_valid_hold", 32'(last_valid), 32'd1);
      chk("bp_data_hold", 32'(last_data), 32'(sd));
      chk("bp_w_hold", 32'(last_w), 32'(sw));
      chk("bp_h_hold", 32'(last_h), 32'(sh));
    end
    drain("bp_drain");
    step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Overflow: six captures with the consumer stalled; the sixth is dropped.
    for (int k = 0; k < 6; k++) begin
      en = 8'($urandom_range(1, 255));
      step(en, {$urandom, $urandom}, 1'b0, 1'b0, k < 5);
    end
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd1);
    sd = m_data;
    step(8'h00, 64'h0, 1'b0, 1'b1, 1'b1);
    chk("fs_clr_ovf", 32'(overflow), 32'd0);
    chk("fs_keep_full", 32'(full), 32'd1);
    chk("fs_keep_data", 32'(m_data), 32'(sd));
    chk("fs_keep_valid", 32'(m_valid), 32'd1);
    step(8'h01, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
    chk("fs_drop_ovf_wins", 32'(overflow), 32'd1);
    step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    step(8'h00, 64'h0, 1'b1, 1'b1, 1'b1);
    chk("fs_hs_w", 32'(m_w), 32'd0);
    drain("ovf_drain");

    // Address wrap: 641 single-lane bytes from a fresh frame.
    step(8'h00, 64'h0, 1'b1, 1'b1, 1'b1);
    chk("wrap_ovf_clr", 32'(overflow), 32'd0);
    for (int n = 0; n < 641; n++) begin
      lane = $urandom_range(0, 7);
      step(8'(1 << lane), {$urandom, $urandom}, 1'b1, 1'b0, 1'b1);
    end
    drain("wrap_drain");
    chk("wrap_count", 32'(idx), 32'd641);
    chk("wrap_w", 32'(m_w), 32'd1);
    chk("wrap_h", 32'(m_h), 32'd0);

    // Back-to-back full-mask entries stream 16 bytes without a gap.
    step(8'hFF, {$urandom, $urandom}, 1'b1, 1'b0, 1'b1);
    step(8'hFF, {$urandom, $urandom}, 1'b1, 1'b0, 1'b1);
    run = 0; maxrun = 0;
    for (int k = 0; k < 24; k++) begin
      step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
      run = last_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    chk("b2b_run", 32'(maxrun), 32'd16);
    chk("b2b_empty", 32'(exp_q.size()), 32'd0);

    // Random traffic, capture rate limited so nothing is dropped.
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      if (rem_q.size() >= DEPTH) en = 8'h00;
      step(en, {$urandom, $urandom}, $urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0, 1'b1);
    end
    drain("rand_drain");
    chk("rand_no_ovf", 32'(overflow), 32'd0);

    // Reset while the third byte of a full-mask entry is on the output.
    step(8'hFF, {$urandom, $urandom}, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 6 && !last_valid; k++) step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    chk("mid_valid_pre", 32'(m_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("mid_valid", 32'(m_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_data", 32'(m_data), 32'd0);
    chk("mid_full", 32'(full), 32'd0);
    exp_q.delete(); rem_q.delete(); idx = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    step(8'h81, {$urandom, $urandom}, 1'b1, 1'b0, 1'b1);
    step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    chk("post_rst_first_w", 32'(last_w), 32'd0);
    chk("post_rst_first_h", 32'(last_h), 32'd0);
    drain("post_rst_drain");
    for (int k = 0; k < 4; k++) step(8'h00, 64'h0, 1'b1, 1'b0, 1'b1);
    chk("post_rst_bytes", 32'(idx), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npu_out_collector.md
NPU_OUT_COLLECTOR -- requirements
Module: npu_out_collector

Interface
REQ-001 Parameter WIDTH, default 80: feature-map row length, the number of column positions per row.
REQ-002 Parameter HEIGHT, default 8: feature-map row count.
REQ-003 Parameter WIDTH_B, default 7: column address width.
REQ-004 Parameter HEIGHT_B, default 3: row address width.
REQ-005 Parameter DEPTH, default 4: capture FIFO entries, power of two.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 out  input  64  eight 8-bit lanes from the arithmetic stage; lane i = out[8i+7:8i].
REQ-009 out_en  input  8  per-lane valid for out, sampled every cycle.
REQ-010 frame_start  input  1  single-cycle pulse; clears the write-back address and the overflow flag.
REQ-011 m_data  output  8  serialized result byte.
REQ-012 m_w  output  WIDTH_B  write-back column address of m_data.
REQ-013 m_h  output  HEIGHT_B  write-back row address of m_data.
REQ-014 m_valid  output  1  m_data, m_w and m_h are valid.
REQ-015 m_ready  input  1  consumer accepts the byte when m_valid and m_ready are both high.
REQ-016 full  output  1  FIFO holds DEPTH entries.
REQ-017 overflow  output  1  sticky flag: a capture was dropped.
REQ-018 busy  output  1  FIFO non-empty or FSM in SEND.

Function
REQ-019 Capture: in any cycle where out_en != 0, push {out, out_en} into the FIFO; when out_en == 0, push nothing.
REQ-020 Push while full without a simultaneous pop: drop the entry, leave FIFO contents unchanged, set overflow.
REQ-021 Push and pop in the same cycle while full: accept the push; occupancy stays DEPTH.
REQ-022 FSM has two states, IDLE and SEND; a hold register stores {data, mask}.
REQ-023 IDLE with FIFO non-empty: pop the head entry into the hold register and go to SEND.
REQ-024 IDLE with FIFO empty: remain in IDLE.
REQ-025 SEND: m_valid = 1; m_data = byte of the lowest-indexed lane whose mask bit is set.
REQ-026 SEND handshake: clear that lane's mask bit.
REQ-027 SEND, handshake on the last set bit, FIFO non-empty: pop the next entry into hold in the same edge, with no bubble.
REQ-028 SEND, handshake on the last set bit, FIFO empty: go to IDLE.
REQ-029 SEND without handshake: hold m_data, m_w, m_h and m_valid stable.
REQ-030 m_valid is 0 in IDLE.
REQ-031 Latency: a capture at edge t into an empty FIFO with the FSM in IDLE gives m_valid high in the cycle after edge t+1, i.e. two cycles after out_en is presented.
REQ-032 Address counters (m_w, m_h): increment on each handshake.
REQ-033 Column wrap: m_w == WIDTH-1 wraps m_w to 0 and increments m_h.
REQ-034 Row wrap: m_h == HEIGHT-1 wraps m_h to 0.
REQ-035 frame_start sets m_w = 0, m_h = 0 and overflow = 0.
REQ-036 frame_start in the same cycle as a handshake: the transferred byte carries the old address; the counters still become 0 (frame_start wins).
REQ-037 frame_start in the same cycle as a dropped push: overflow ends at 1 (set wins over clear).
REQ-038 frame_start leaves the FIFO, the FSM and the hold register unchanged.
REQ-039 full = (occupancy == DEPTH); busy = (occupancy != 0) OR (state == SEND).

Reset
REQ-040 reset low: immediately, without waiting for clk, empty the FIFO and set the FSM to IDLE.
REQ-041 reset low: clear the hold register and set m_w = 0, m_h = 0, overflow = 0.
REQ-042 Outputs while reset is low: m_valid = 0, m_data = 0, full = 0, busy = 0.
REQ-043 Reset asserted mid-transfer discards any partially serialized entry; no byte from it appears after reset deasserts.
REQ-044 First capture is possible on the first rising edge after reset deasserts.

Verification
REQ-045 Single entry: out_en = 8'b1010_0101 with lanes 0..7 = 0x10..0x17, m_ready = 1 -> bytes 0x10, 0x12, 0x15, 0x17 at (w,h) = (0,0), (1,0), (2,0), (3,0) on consecutive cycles; m_valid rises two cycles after capture.
REQ-046 Backpressure: hold m_ready = 0 for 5 cycles during SEND -> m_data, m_w and m_h stay constant; no byte is lost or duplicated.
REQ-047 Overflow: m_ready = 0, apply 6 consecutive captures with DEPTH = 4 -> the first goes to hold, the next four fill the FIFO, the sixth is dropped; full = 1, overflow = 1; a frame_start pulse then clears overflow only.
REQ-048 Wrap: stream 81 single-lane bytes -> byte 80 is at (79,0), byte 81 at (0,1); after 640 bytes, h returns to 0.
REQ-049 Back-to-back: two full-mask entries -> 16 bytes with m_valid high for 16 consecutive cycles, no gap.
REQ-050 Reset mid-operation: pull reset low at the third byte of a full-mask entry -> m_valid drops immediately and busy = 0; after release, a new capture emits from (0,0).
